reaction_sequencer: RTL and testbench

Top-level controller for the reaction-timer datapath. It sequences the LFSR random-delay source, the 100 Hz tick, the two-digit BCD counter and the stimulus LED. It takes the raw push button, runs the idle → random wait → react → show cycle, detects false starts and timeouts, and latches the measured BCD result for the seven-segment decoders.

---
 rtl/reaction_pkg.sv | 27 ++
 rtl/reaction_sequencer_button_sync_edge.sv | 42 ++++
 rtl/reaction_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_reaction_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// ---------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction-timer datapath:
//   - state_e         : sequencer state encoding (IDLE..SHOW)
//   - TIMEOUT_BCD_DEF : default BCD count that forces a timeout
//   - TICK_HZ         : rate of the tick strobe feeding the sequencer
//   - bcd_pair_t      : two packed BCD digits {d1,d0}
// ---------------------------------------------------------------------------
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_REACT = 3'd3,
    ST_SHOW  = 3'd4
  } state_e;

  localparam logic [7:0]  TIMEOUT_BCD_DEF = 8'h99;
  localparam int unsigned TICK_HZ         = 100;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_pair_t;

endpackage

// File: rtl/reaction_sequencer_button_sync_edge.sv
// ---------------------------------------------------------------------------
// button_sync_edge
// Two-flop synchroniser for an active-low asynchronous push button followed
// by a falling-edge one-shot. Holding the button yields a single pulse.
// Pin-to-pulse latency is 3 clock cycles.
// Ports:
//   i_clk   in  1  clock
//   i_rst   in  1  asynchronous active-high reset
//   i_btn_n in  1  raw button, active-low, asynchronous to i_clk
//   o_press out 1  one-cycle press pulse (registered)
// ---------------------------------------------------------------------------
module button_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_sync0;
  logic r_sync1;
  logic r_prev;
  logic r_press;

  // Synchroniser and history reset to the released level so that leaving
  // reset never produces a spurious press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_prev  <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_sync0 <= i_btn_n;
      r_sync1 <= r_sync0;
      r_prev  <= r_sync1;
      r_press <= r_prev & ~r_sync1;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/reaction_sequencer.sv
// ---------------------------------------------------------------------------
// reaction_sequencer
// Top-level controller of the reaction timer: runs IDLE -> ARM -> WAIT ->
// REACT -> SHOW, loads a random wait from the LFSR, detects false starts and
// timeouts, and latches the measured BCD reaction time.
// Ports:
//   Clock        in  1        system clock
//   Reset        in  1        asynchronous active-high reset
//   Pushn        in  1        raw push button, active-low, asynchronous
//   tick         in  1        single-cycle 100 Hz strobe
//   rand_val     in  DELAY_W  LFSR output
//   bcd_in       in  8        {BCD1,BCD0} from the BCD counter
//   led          out 1        stimulus LED (REACT only)
//   cnt_en       out 1        BCD counter enable (counter qualifies by tick)
//   cnt_clr      out 1        one-cycle BCD counter clear
//   lfsr_en      out 1        LFSR run enable
//   result       out 8        latched BCD reaction time
//   result_valid out 1        result holds a genuine reaction
//   false_start  out 1        press before LED lit
//   timeout      out 1        no press before TIMEOUT_BCD
//   state        out 3        current state code
// Optional (macro REACTION_BEST_EN):
//   best         out 8        best valid result since reset (reset 8'h99)
//   best_new     out 1        one-cycle pulse when best improves
// ---------------------------------------------------------------------------
module reaction_sequencer
  import reaction_pkg::*;
#(
  parameter int unsigned DELAY_W     = 4,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned MIN_DELAY   = TICK_HZ / 2,
  parameter int unsigned DELAY_SCALE = 8,
  parameter logic [7:0]  TIMEOUT_BCD = TIMEOUT_BCD_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Pushn,
  input  logic               tick,
  input  logic [DELAY_W-1:0] rand_val,
  input  logic [7:0]         bcd_in,
  output logic               led,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               lfsr_en,
  output logic [7:0]         result,
  output logic               result_valid,
  output logic               false_start,
  output logic               timeout,
  output logic [2:0]         state
`ifdef REACTION_BEST_EN
  ,
  output logic [7:0]         best,
  output logic               best_new
`endif
);

  logic w_press;

  button_sync_edge u_btn (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_btn_n (Pushn),
    .o_press (w_press)
  );

  state_e           r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_dly,     w_dly_nxt;
  bcd_pair_t        r_result,  w_result_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_fs,      w_fs_nxt;
  logic             r_to,      w_to_nxt;
  logic             r_led,     w_led_nxt;
  logic             r_cnt_en,  w_cnt_en_nxt;
  logic             r_cnt_clr, w_cnt_clr_nxt;
  logic             r_lfsr_en, w_lfsr_en_nxt;
  logic [CNT_W-1:0] w_dly_load;

  assign w_dly_load = CNT_W'(MIN_DELAY) + CNT_W'(rand_val) * CNT_W'(DELAY_SCALE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_dly     <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_fs      <= 1'b0;
      r_to      <= 1'b0;
      r_led     <= 1'b0;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_lfsr_en <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_dly     <= w_dly_nxt;
      r_result  <= w_result_nxt;
      r_valid   <= w_valid_nxt;
      r_fs      <= w_fs_nxt;
      r_to      <= w_to_nxt;
      r_led     <= w_led_nxt;
      r_cnt_en  <= w_cnt_en_nxt;
      r_cnt_clr <= w_cnt_clr_nxt;
      r_lfsr_en <= w_lfsr_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dly_nxt    = r_dly;
    w_result_nxt = r_result;
    w_valid_nxt  = r_valid;
    w_fs_nxt     = r_fs;
    w_to_nxt     = r_to;

    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_state_nxt  = ST_ARM;
          w_dly_nxt    = w_dly_load;
          // Flags are cleared on entry so they already read 0 during ARM.
          w_result_nxt = '0;
          w_valid_nxt  = 1'b0;
          w_fs_nxt     = 1'b0;
          w_to_nxt     = 1'b0;
        end
      end
      ST_ARM: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Press is tested first so it wins over a coincident expiry.
        if (w_press) begin
          w_state_nxt  = ST_SHOW;
          w_fs_nxt     = 1'b1;
          w_result_nxt = '0;
        end else if (tick) begin
          if (r_dly == '0) begin
            w_state_nxt = ST_REACT;
          end else begin
            w_dly_nxt = r_dly - CNT_W'(1);
          end
        end
      end
      ST_REACT: begin
        // Press is tested first so it wins over a coincident timeout.
        if (w_press) begin
          w_state_nxt  = ST_SHOW;
          w_result_nxt = bcd_in;
          w_valid_nxt  = 1'b1;
        end else if (bcd_in == TIMEOUT_BCD) begin
          w_state_nxt  = ST_SHOW;
          w_result_nxt = TIMEOUT_BCD;
          w_to_nxt     = 1'b1;
        end
      end
      ST_SHOW: begin
        if (w_press) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Control outputs are decoded from the next state and registered, so
    // they change on the same edge as the state they belong to.
    w_led_nxt     = (w_state_nxt == ST_REACT);
    w_cnt_en_nxt  = (w_state_nxt == ST_REACT);
    w_cnt_clr_nxt = (w_state_nxt == ST_ARM);
    w_lfsr_en_nxt = (w_state_nxt != ST_ARM);
  end

  assign led          = r_led;
  assign cnt_en       = r_cnt_en;
  assign cnt_clr      = r_cnt_clr;
  assign lfsr_en      = r_lfsr_en;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign false_start  = r_fs;
  assign timeout      = r_to;
  assign state        = r_state;

`ifdef REACTION_BEST_EN
  logic [7:0] r_best;
  logic       r_best_new;
  logic       w_best_hit;

  // Packed BCD digits order the same as binary, so a plain compare suffices.
  assign w_best_hit = (r_state == ST_REACT) && w_press && (bcd_in < r_best);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_best     <= 8'h99;
      r_best_new <= 1'b0;
    end else begin
      r_best_new <= w_best_hit;
      if (w_best_hit) begin
        r_best <= bcd_in;
      end
    end
  end

  assign best     = r_best;
  assign best_new = r_best_new;
`endif

endmodule

// File: tb/tb_reaction_sequencer.sv
module tb_reaction_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Pushn;
  logic       tick;
  logic [3:0] rand_val;
  logic [7:0] bcd_in;
  logic       led;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lfsr_en;
  logic [7:0] result;
  logic       result_valid;
  logic       false_start;
  logic       timeout;
  logic [2:0] state;
`ifdef REACTION_BEST_EN
  logic [7:0] best;
  logic       best_new;
`endif

  reaction_sequencer #(
    .DELAY_W     (4),
    .CNT_W       (10),
    .MIN_DELAY   (50),
    .DELAY_SCALE (8),
    .TIMEOUT_BCD (8'h99)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Pushn        (Pushn),
    .tick         (tick),
    .rand_val     (rand_val),
    .bcd_in       (bcd_in),
    .led          (led),
    .cnt_en       (cnt_en),
    .cnt_clr      (cnt_clr),
    .lfsr_en      (lfsr_en),
    .result       (result),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout),
    .state        (state)
`ifdef REACTION_BEST_EN
    ,
    .best         (best),
    .best_new     (best_new)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] res;
    logic       v;
    logic       fs;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [7:0] res, input logic v, input logic fs, input logic to);
    exp_t e;
    e.res = res; e.v = v; e.fs = fs; e.to = to;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for SHOW, then pops the expected outcome and compares.
  task automatic show_check(input string tag);
    exp_t e;
    for (int i = 0; i < 8 && state !== 3'd4; i++) @(negedge Clock);
    chk8({tag, "_state"}, 8'(state), 8'd4);
    if (sb_q.size() == 0) begin
      chk1({tag, "_sb_nonempty"}, 1'b0, 1'b1);
    end else begin
      e = sb_q.pop_front();
      chk8({tag, "_result"}, result, e.res);
      chk1({tag, "_valid"}, result_valid, e.v);
      chk1({tag, "_false_start"}, false_start, e.fs);
      chk1({tag, "_timeout"}, timeout, e.to);
      chk1({tag, "_led"}, led, 1'b0);
      chk1({tag, "_cnt_en"}, cnt_en, 1'b0);
    end
  endtask

  // Drive the pin low; the synchronised press pulse is visible 3 cycles later.
  task automatic press_start();
    Pushn = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic press_release();
    Pushn = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic give_tick();
    tick = 1'b1;
    @(negedge Clock);
    tick = 1'b0;
    @(negedge Clock);
  endtask

  // Full press from IDLE into WAIT; checks ARM and that holding adds no press.
  task automatic start_run(input logic [3:0] rv, input string tag);
    rand_val = rv;
    bcd_in   = 8'h00;
    press_start();
    @(negedge Clock);
    chk8({tag, "_arm_state"}, 8'(state), 8'd1);
    chk1({tag, "_arm_clr"}, cnt_clr, 1'b1);
    chk1({tag, "_arm_lfsr"}, lfsr_en, 1'b0);
    @(negedge Clock);
    chk8({tag, "_wait_state"}, 8'(state), 8'd2);
    chk1({tag, "_clr_once"}, cnt_clr, 1'b0);
    press_release();
    chk8({tag, "_hold_state"}, 8'(state), 8'd2);
  endtask

  task automatic reach_react(input logic [3:0] rv, input string tag);
    int n;
    start_run(rv, tag);
    n = 50 + int'(rv) * 8;
    repeat (n) give_tick();
    chk1({tag, "_led_before"}, led, 1'b0);
    give_tick();
    chk1({tag, "_led_up"}, led, 1'b1);
    chk8({tag, "_react_state"}, 8'(state), 8'd3);
  endtask

  task automatic back_to_idle(input string tag);
    press_start();
    @(negedge Clock);
    chk8({tag, "_idle_state"}, 8'(state), 8'd0);
    press_release();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset    = 1'b1;
    Pushn    = 1'b1;
    tick     = 1'b0;
    rand_val = 4'd0;
    bcd_in   = 8'h00;
    repeat (3) @(negedge Clock);
    chk8("rst_state", 8'(state), 8'd0);
    chk1("rst_led", led, 1'b0);
    chk1("rst_lfsr", lfsr_en, 1'b1);
    chk1("rst_cnt_en", cnt_en, 1'b0);
    chk1("rst_cnt_clr", cnt_clr, 1'b0);
    chk8("rst_result", result, 8'h00);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    // Normal reaction: rand 3 -> 74 ticks to zero, expiry on the 75th.
    reach_react(4'd3, "norm");
    chk1("norm_cnt_en", cnt_en, 1'b1);
    repeat (23) give_tick();
    bcd_in = 8'h23;
    sb_push(8'h23, 1'b1, 1'b0, 1'b0);
    press_start();
    @(negedge Clock);
    show_check("norm");
    press_release();
    back_to_idle("norm");
    chk8("norm_hold_result", result, 8'h23);
    chk1("norm_hold_valid", result_valid, 1'b1);

    // False start 10 ticks into WAIT.
    start_run(4'd5, "fs");
    repeat (10) give_tick();
    chk1("fs_led_low", led, 1'b0);
    sb_push(8'h00, 1'b0, 1'b1, 1'b0);
    press_start();
    @(negedge Clock);
    show_check("fs");
    press_release();
    back_to_idle("fs");

    // Timeout in REACT.
    reach_react(4'd0, "to");
    bcd_in = 8'h98;
    repeat (3) give_tick();
    chk8("to_still_react", 8'(state), 8'd3);
    sb_push(8'h99, 1'b0, 1'b0, 1'b1);
    bcd_in = 8'h99;
    @(negedge Clock);
    show_check("to");
    bcd_in = 8'h00;
    back_to_idle("to");

    // Press coincident with delay expiry: false start wins.
    start_run(4'd0, "cx");
    repeat (50) give_tick();
    sb_push(8'h00, 1'b0, 1'b1, 1'b0);
    press_start();
    tick = 1'b1;
    @(negedge Clock);
    tick = 1'b0;
    show_check("cx");
    press_release();
    back_to_idle("cx");

    // Press coincident with the timeout value: press wins.
    reach_react(4'd0, "ct");
    bcd_in = 8'h98;
    sb_push(8'h99, 1'b1, 1'b0, 1'b0);
    press_start();
    bcd_in = 8'h99;
    @(negedge Clock);
    show_check("ct");
    bcd_in = 8'h00;
    press_release();
    back_to_idle("ct");

    // Asynchronous reset in the middle of REACT.
    reach_react(4'd1, "mr");
    #2 Reset = 1'b1;
    @(negedge Clock);
    chk8("mr_state", 8'(state), 8'd0);
    chk1("mr_led", led, 1'b0);
    chk1("mr_lfsr", lfsr_en, 1'b1);
    chk1("mr_cnt_en", cnt_en, 1'b0);
    chk8("mr_result", result, 8'h00);
    chk1("mr_valid", result_valid, 1'b0);
    chk1("mr_timeout", timeout, 1'b0);
    chk1("mr_fs", false_start, 1'b0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

`ifdef REACTION_BEST_EN
    begin
      logic [7:0] vals [3];
      logic       news [3];
      logic [7:0] exp_best;
      vals = '{8'h40, 8'h31, 8'h35};
      news = '{1'b1, 1'b1, 1'b0};
      exp_best = 8'h99;
      chk8("best_rst", best, exp_best);
      for (int k = 0; k < 3; k++) begin
        reach_react(4'd0, "bst");
        bcd_in = vals[k];
        sb_push(vals[k], 1'b1, 1'b0, 1'b0);
        if (vals[k] < exp_best) exp_best = vals[k];
        press_start();
        @(negedge Clock);
        show_check("bst");
        chk1("best_new_pulse", best_new, news[k]);
        chk8("best_val", best, exp_best);
        @(negedge Clock);
        chk1("best_new_drop", best_new, 1'b0);
        bcd_in = 8'h00;
        press_release();
        back_to_idle("bst");
      end
      chk8("best_final", best, 8'h31);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
